// File: rtl/mips_bus_port_pkg.sv
// ---------------------------------------------------------------------------
// mips_bus_port_pkg
// Shared types for the MIPS load/store/fetch bus port.
//   mem_op_t          : CPU-side access type (word, half, byte, LWL, LWR)
//   port_state_t      : bus port FSM states
//   toggle_endianness : byte swap between big-endian CPU and little-endian bus
// ---------------------------------------------------------------------------
package mips_bus_port_pkg;

   typedef enum logic [2:0] {
      OP_W  = 3'd0,
      OP_H  = 3'd1,
      OP_B  = 3'd2,
      OP_WL = 3'd3,
      OP_WR = 3'd4
   } mem_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } port_state_t;

   function automatic logic [31:0] toggle_endianness(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

endpackage

// File: rtl/mips_bus_port_lane_format.sv
// ---------------------------------------------------------------------------
// bus_lane_format
// Combinational lane steering between the big-endian CPU view and the
// little-endian Avalon data bus.
//   op          in  3   mem_op_t access type
//   k           in  2   byte offset within the word
//   sign_ext    in  1   sign-extend half/byte loads
//   readdata    in  32  raw bus read data
//   rt          in  32  current rt, merged by LWL/LWR
//   wdata       in  32  store data, big-endian, right-justified for H/B
//   byteenable  out 4   lane enables for the access
//   writedata   out 32  bus-order store data (H/B replicated in all lanes)
//   load_result out 32  merged/extended load value
// ---------------------------------------------------------------------------
import mips_bus_port_pkg::*;

module bus_lane_format (
   input  logic [2:0]  op,
   input  logic [1:0]  k,
   input  logic        sign_ext,
   input  logic [31:0] readdata,
   input  logic [31:0] rt,
   input  logic [31:0] wdata,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   output logic [31:0] load_result
);

   logic [31:0] w;
   logic [7:0]  lane_b;
   logic [15:0] half;
   logic [4:0]  sh_l;
   logic [4:0]  sh_r;

   always_comb begin
      w      = toggle_endianness(readdata);
      lane_b = readdata[{k, 3'b000} +: 8];
      // Big-endian halfword: lower-address lane is the high byte.
      half   = k[1] ? {readdata[23:16], readdata[31:24]}
                    : {readdata[7:0],   readdata[15:8]};
      sh_l   = {k, 3'b000};
      // 8*(3-k): for a 2-bit k, 3-k equals ~k.
      sh_r   = {~k, 3'b000};

      byteenable  = '0;
      writedata   = '0;
      load_result = '0;

      case (mem_op_t'(op))
         OP_W: begin
            byteenable  = 4'b1111;
            writedata   = toggle_endianness(wdata);
            load_result = w;
         end
         OP_H: begin
            byteenable  = k[1] ? 4'b1100 : 4'b0011;
            writedata   = {2{wdata[7:0], wdata[15:8]}};
            load_result = {{16{sign_ext & half[15]}}, half};
         end
         OP_B: begin
            byteenable  = 4'b0001 << k;
            writedata   = {4{wdata[7:0]}};
            load_result = {{24{sign_ext & lane_b[7]}}, lane_b};
         end
         OP_WL: begin
            byteenable  = 4'b1111 << k;
            load_result = (w << sh_l) | (rt & ((32'd1 << sh_l) - 32'd1));
         end
         OP_WR: begin
            byteenable  = 4'b1111 >> (~k);
            load_result = (w >> sh_r) | (rt & ~(32'hFFFF_FFFF >> sh_r));
         end
         default: begin
            byteenable  = '0;
            writedata   = '0;
            load_result = '0;
         end
      endcase
   end

endmodule

// File: rtl/mips_bus_port.sv
// ---------------------------------------------------------------------------
// mips_bus_port
// Converts one CPU memory request (W/H/B/LWL/LWR) into a single Avalon-MM
// master transaction, with waitrequest stalls, an optional watchdog and a
// one-cycle response pulse carrying the merged/extended load result.
//
// Parameters:
//   ADDR_W         address width (>= 2)
//   TIMEOUT_CYCLES consecutive waitrequest-high BUS cycles before abort;
//                  0 disables the watchdog
// Build option:
//   MIPS_BUS_PORT_ALIGN_CHECK_EN  misaligned OP_W/OP_H fault without a bus
//                                 cycle; otherwise low address bits are ignored
//
// Ports:
//   clk, reset (sync, active-high)
//   CPU side : req_valid, req_ready, req_write, req_op, req_signed, req_addr,
//              req_wdata, req_rt, resp_valid, resp_rdata, resp_err
//   Avalon   : address, read, write, waitrequest, writedata, byteenable,
//              readdata
// ---------------------------------------------------------------------------
import mips_bus_port_pkg::*;

module mips_bus_port #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_op,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [31:0]       req_rt,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] address,
   output logic              read,
   output logic              write,
   input  logic              waitrequest,
   output logic [31:0]       writedata,
   output logic [3:0]        byteenable,
   input  logic [31:0]       readdata
);

   port_state_t state;

   logic [2:0]  op_q;
   logic [1:0]  k_q;
   logic        sign_q;
   logic        write_q;
   logic [31:0] rt_q;
   logic [31:0] wd_cnt;

   logic [2:0]  fmt_op;
   logic [1:0]  fmt_k;
   logic        fmt_sign;
   logic [31:0] fmt_rt;
   logic [3:0]  fmt_be;
   logic [31:0] fmt_wd;
   logic [31:0] fmt_ld;

   logic        align_bad;
   logic        req_bad;
   logic        timeout_hit;

   // One formatter serves both phases: in IDLE it sees the live request to
   // build byteenable/writedata; in BUS it sees the latched request to build
   // the load result from readdata.
   always_comb begin
      if (state == IDLE) begin
         fmt_op   = req_op;
         fmt_k    = req_addr[1:0];
         fmt_sign = req_signed;
         fmt_rt   = req_rt;
      end else begin
         fmt_op   = op_q;
         fmt_k    = k_q;
         fmt_sign = sign_q;
         fmt_rt   = rt_q;
      end
   end

   bus_lane_format u_fmt (
      .op          (fmt_op),
      .k           (fmt_k),
      .sign_ext    (fmt_sign),
      .readdata    (readdata),
      .rt          (fmt_rt),
      .wdata       (req_wdata),
      .byteenable  (fmt_be),
      .writedata   (fmt_wd),
      .load_result (fmt_ld)
   );

   always_comb begin
`ifdef MIPS_BUS_PORT_ALIGN_CHECK_EN
      align_bad = ((req_op == OP_W) && (req_addr[1:0] != 2'b00)) ||
                  ((req_op == OP_H) && req_addr[0]);
`else
      align_bad = 1'b0;
`endif
      // LWL/LWR have no store form; unknown op codes fault the same way.
      req_bad = align_bad ||
                (req_write && ((req_op == OP_WL) || (req_op == OP_WR))) ||
                (req_op > OP_WR);
      timeout_hit = (TIMEOUT_CYCLES != 0) && (wd_cnt == TIMEOUT_CYCLES - 1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         address    <= '0;
         read       <= 1'b0;
         write      <= 1'b0;
         writedata  <= '0;
         byteenable <= '0;
         op_q       <= '0;
         k_q        <= '0;
         sign_q     <= 1'b0;
         write_q    <= 1'b0;
         rt_q       <= '0;
         wd_cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q      <= req_op;
                  k_q       <= req_addr[1:0];
                  sign_q    <= req_signed;
                  write_q   <= req_write;
                  rt_q      <= req_rt;
                  req_ready <= 1'b0;
                  if (req_bad) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else begin
                     state      <= BUS;
                     read       <= ~req_write;
                     write      <= req_write;
                     address    <= {req_addr[ADDR_W-1:2], 2'b00};
                     byteenable <= fmt_be;
                     writedata  <= fmt_wd;
                     wd_cnt     <= '0;
                  end
               end
            end
            BUS: begin
               if (!waitrequest) begin
                  read       <= 1'b0;
                  write      <= 1'b0;
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= write_q ? '0 : fmt_ld;
               end else if (timeout_hit) begin
                  read       <= 1'b0;
                  write      <= 1'b0;
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
               end else if (wd_cnt != '1) begin
                  wd_cnt <= wd_cnt + 32'd1;
               end
            end
            RESP: begin
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_bus_port.sv
import mips_bus_port_pkg::*;

module tb_mips_bus_port;

   localparam int unsigned TO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_op;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_rt;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic        waitrequest;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata;

   int checks   = 0;
   int failures = 0;

   mips_bus_port #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_op      (req_op),
      .req_signed  (req_signed),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_rt      (req_rt),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .address     (address),
      .read        (read),
      .write       (write),
      .waitrequest (waitrequest),
      .writedata   (writedata),
      .byteenable  (byteenable),
      .readdata    (readdata)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Reference model: bytes in address order, big-endian CPU values.
   task automatic model(input logic wr, input logic [2:0] op, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rt, input logic [31:0] rd,
                        output logic [3:0] be, output logic [31:0] wd,
                        output logic [31:0] ld, output logic err);
      logic [7:0]  b [4];
      logic [7:0]  s [4];
      logic [31:0] wv;
      logic [15:0] hv;
      int k, h;
      k = int'(addr[1:0]);
      h = k / 2;
      for (int i = 0; i < 4; i++) begin
         b[i] = rd[8*i +: 8];
         s[i] = 8'h00;
      end
      wv  = {b[0], b[1], b[2], b[3]};
      be  = '0;
      ld  = '0;
      err = 1'b0;
      case (op)
         OP_W: begin
            for (int i = 0; i < 4; i++) begin
               be[i] = 1'b1;
               s[i]  = wdata[8*(3-i) +: 8];
            end
            ld = wv;
         end
         OP_H: begin
            be[2*h]   = 1'b1;
            be[2*h+1] = 1'b1;
            for (int i = 0; i < 4; i++) s[i] = (i % 2 == 0) ? wdata[15:8] : wdata[7:0];
            hv = {b[2*h], b[2*h+1]};
            ld = {{16{sgn & hv[15]}}, hv};
         end
         OP_B: begin
            be[k] = 1'b1;
            for (int i = 0; i < 4; i++) s[i] = wdata[7:0];
            ld = {{24{sgn & b[k][7]}}, b[k]};
         end
         OP_WL: begin
            for (int i = 0; i < 4; i++) be[i] = (i >= k);
            ld = (wv << (8*k)) | (rt & ((32'h1 << (8*k)) - 32'h1));
         end
         OP_WR: begin
            for (int i = 0; i < 4; i++) be[i] = (i <= k);
            ld = (wv >> (8*(3-k))) | (rt & ~(32'hFFFF_FFFF >> (8*(3-k))));
         end
         default: err = 1'b1;
      endcase
      wd = {s[3], s[2], s[1], s[0]};
      if (wr && (op == OP_WL || op == OP_WR)) err = 1'b1;
`ifdef MIPS_BUS_PORT_ALIGN_CHECK_EN
      if ((op == OP_W && k != 0) || (op == OP_H && (k % 2) == 1)) err = 1'b1;
`endif
      if (wr || err) ld = '0;
   endtask

   task automatic do_txn(input string tag, input logic wr, input logic [2:0] op,
                         input logic sgn, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rt,
                         input logic [31:0] rd, input int unsigned nwait);
      logic [3:0]  ebe;
      logic [31:0] ewd, eld;
      logic        eerr;
      model(wr, op, sgn, addr, wdata, rt, rd, ebe, ewd, eld, eerr);
      @(negedge clk);
      chk({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
      req_valid   = 1'b1;
      req_write   = wr;
      req_op      = op;
      req_signed  = sgn;
      req_addr    = addr;
      req_wdata   = wdata;
      req_rt      = rt;
      readdata    = rd;
      waitrequest = (nwait != 0);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (eerr) begin
         chk({tag, "_err_rv"},    32'(resp_valid), 32'd1);
         chk({tag, "_err_flag"},  32'(resp_err),   32'd1);
         chk({tag, "_err_rdata"}, resp_rdata,      32'd0);
         chk({tag, "_err_nostb"}, 32'({read, write}), 32'd0);
         @(posedge clk);
         #1;
         chk({tag, "_err_rv_drop"}, 32'(resp_valid), 32'd0);
      end else begin
         chk({tag, "_read"},  32'(read),  32'(!wr));
         chk({tag, "_write"}, 32'(write), 32'(wr));
         chk({tag, "_addr"},  address, addr & 32'hFFFF_FFFC);
         chk({tag, "_be"},    32'(byteenable), 32'(ebe));
         if (wr) chk({tag, "_wdata"}, writedata, ewd);
         chk({tag, "_ready_bus"}, 32'(req_ready), 32'd0);
         for (int i = 0; i < int'(nwait); i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_stb"}, 32'({read, write}), 32'({!wr, wr}));
            chk({tag, "_hold_be"},  32'(byteenable), 32'(ebe));
            chk({tag, "_no_rv"},    32'(resp_valid), 32'd0);
            if (i == int'(nwait) - 1) waitrequest = 1'b0;
         end
         @(posedge clk);
         #1;
         chk({tag, "_rv"},    32'(resp_valid), 32'd1);
         chk({tag, "_rdata"}, resp_rdata, eld);
         chk({tag, "_rerr"},  32'(resp_err), 32'd0);
         chk({tag, "_stb_drop"}, 32'({read, write}), 32'd0);
         @(posedge clk);
         #1;
         chk({tag, "_rv_drop"},    32'(resp_valid), 32'd0);
         chk({tag, "_rdata_hold"}, resp_rdata, eld);
      end
   endtask

   initial begin
      logic        r_wr;
      logic [2:0]  r_op;
      reset       = 1'b1;
      req_valid   = 1'b0;
      req_write   = 1'b0;
      req_op      = 3'd0;
      req_signed  = 1'b0;
      req_addr    = '0;
      req_wdata   = '0;
      req_rt      = '0;
      waitrequest = 1'b0;
      readdata    = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_read",   32'(read),       32'd0);
      chk("rst_write",  32'(write),      32'd0);
      chk("rst_rv",     32'(resp_valid), 32'd0);
      chk("rst_rerr",   32'(resp_err),   32'd0);
      chk("rst_addr",   address,         32'd0);
      chk("rst_wdata",  writedata,       32'd0);
      chk("rst_rdata",  resp_rdata,      32'd0);
      chk("rst_be",     32'(byteenable), 32'd0);
      chk("rst_ready",  32'(req_ready),  32'd1);
      @(negedge clk);
      reset = 1'b0;

      // Directed scenarios; results come from the model, with key constants cross-checked.
      do_txn("lw100", 1'b0, OP_W, 1'b0, 32'h100, 32'h0, 32'h0, 32'h4433_2211, 0);
      chk("lw100_const", resp_rdata, 32'h1122_3344);
      do_txn("lb103", 1'b0, OP_B, 1'b1, 32'h103, 32'h0, 32'h0, 32'h8033_2211, 0);
      chk("lb103_const", resp_rdata, 32'hFFFF_FF80);
      do_txn("lbu103", 1'b0, OP_B, 1'b0, 32'h103, 32'h0, 32'h0, 32'h8033_2211, 1);
      chk("lbu103_const", resp_rdata, 32'h0000_0080);
      do_txn("sh102", 1'b1, OP_H, 1'b0, 32'h102, 32'h0000_BEEF, 32'h0, 32'h0, 3);
      chk("sh102_wd_const", writedata, 32'hEFBE_EFBE);
      do_txn("lwl101", 1'b0, OP_WL, 1'b0, 32'h101, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 0);
      chk("lwl101_const", resp_rdata, 32'h2233_44DD);
      do_txn("lwr101", 1'b0, OP_WR, 1'b0, 32'h101, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 2);
      chk("lwr101_const", resp_rdata, 32'hAABB_1122);
      do_txn("lw102", 1'b0, OP_W, 1'b0, 32'h102, 32'h0, 32'h0, 32'h4433_2211, 0);
      do_txn("swl_bad", 1'b1, OP_WL, 1'b0, 32'h200, 32'h1234_5678, 32'h0, 32'h0, 0);

      // Watchdog: waitrequest stuck high.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_op = OP_W; req_addr = 32'h300;
      waitrequest = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("wd_read_up", 32'(read), 32'd1);
      for (int i = 2; i <= int'(TO); i++) begin
         @(posedge clk);
         #1;
         chk("wd_read_held", 32'(read), 32'd1);
         chk("wd_no_rv", 32'(resp_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      chk("wd_read_drop", 32'(read), 32'd0);
      chk("wd_rv", 32'(resp_valid), 32'd1);
      chk("wd_err", 32'(resp_err), 32'd1);
      waitrequest = 1'b0;
      @(posedge clk);
      #1;
      chk("wd_rv_drop", 32'(resp_valid), 32'd0);

      // Reset in the middle of a stalled bus cycle.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_op = OP_W; req_addr = 32'h404;
      req_wdata = 32'hCAFE_F00D; waitrequest = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("mid_write_up", 32'(write), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_write", 32'(write), 32'd0);
      chk("mid_rv",    32'(resp_valid), 32'd0);
      chk("mid_addr",  address, 32'd0);
      chk("mid_be",    32'(byteenable), 32'd0);
      chk("mid_wdata", writedata, 32'd0);
      chk("mid_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      waitrequest = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("mid_no_resp", 32'({resp_valid, write}), 32'd0);
      end

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         r_op = 3'($urandom_range(0, 4));
         if (r_op >= 3'd3) r_wr = ($urandom_range(0, 7) == 0);
         else              r_wr = 1'($urandom_range(0, 1));
         do_txn("rnd", r_wr, r_op, 1'($urandom_range(0, 1)), $urandom, $urandom,
                $urandom, $urandom, $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
